// File: rtl/line_instruction_cache_pkg.sv
// Shared types and helpers for the line instruction cache.
package line_instruction_cache_pkg;

    // Refill controller states: IDLE accepts lookups, FILL streams a line in.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Tag width left over from a 32-bit byte address once the byte, word-offset
    // and index fields are removed.
    function automatic int tag_width(input int index_bits, input int offset_bits);
        return 30 - index_bits - offset_bits;
    endfunction

endpackage

// File: rtl/line_instruction_cache_if.sv
// Fetch-side and memory-adaptor-side signals of the instruction cache.
interface line_instruction_cache_if;
    logic [31:0] read_addr;
    logic        is_reading;
    logic [31:0] read_data;
    logic        is_ready;
    logic        icache_available;
    logic [31:0] mem_data_in;
    logic        mem_done;
    logic        mem_request;
    logic [31:0] mem_addr;

    // The cache itself.
    modport slave (
        input  read_addr, is_reading, mem_data_in, mem_done,
        output read_data, is_ready, icache_available, mem_request, mem_addr
    );

    // The fetch unit plus memory adaptor driving the cache.
    modport master (
        output read_addr, is_reading, mem_data_in, mem_done,
        input  read_data, is_ready, icache_available, mem_request, mem_addr
    );
endinterface

// File: rtl/line_instruction_cache_refill_fsm.sv
// Line refill controller: walks the word counter across one line, one adaptor
// transaction per word, and flags the final word.
module icache_refill_fsm
    import line_instruction_cache_pkg::*;
#(
    parameter int OFFSET_BITS = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   abort,
    input  logic                   start,
    input  logic [31:0]            start_addr,
    input  logic                   mem_done,
    output fill_state_e            state,
    output logic [OFFSET_BITS-1:0] ctr,
    output logic [31:0]            fill_addr,
    output logic                   mem_request,
    output logic [31:0]            mem_addr,
    output logic                   word_we,
    output logic                   last_done
);

    fill_state_e            state_d;
    logic [OFFSET_BITS-1:0] ctr_d;

    // State, word counter and missed address; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            ctr       <= '0;
            fill_addr <= '0;
        end else if (rdy_in) begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_d;
            ctr   <= ctr_d;
            if (start) fill_addr <= start_addr;
        end
    end

    // Next state and word strobes; an abort discards any mem_done in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d   = state;
        ctr_d     = ctr;
        word_we   = 1'b0;
        last_done = 1'b0;
        if (abort) begin
            state_d = IDLE;
            ctr_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d = FILL;
                        ctr_d   = '0;
                    end
                end
                FILL: begin
                    if (mem_done && rdy_in) begin
                        word_we = 1'b1;
                        ctr_d   = ctr + 1'b1;
                        if (ctr == '1) begin
                            last_done = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem_request = (state == FILL);
    assign mem_addr    = {fill_addr[31:OFFSET_BITS+2], ctr, 2'b00};

endmodule

// File: rtl/line_instruction_cache.sv
// Direct-mapped instruction cache with multi-word lines: same-cycle hits,
// sequential whole-line refill on a miss, fence.i invalidate, saturating counters.
module line_instruction_cache
    import line_instruction_cache_pkg::*;
#(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_pipline,
    input  logic                  invalidate_all,
    line_instruction_cache_if.slave bus,
    output logic [PERF_WIDTH-1:0] hit_count,
    output logic [PERF_WIDTH-1:0] miss_count
);

    localparam int TAG_BITS = tag_width(INDEX_BITS, OFFSET_BITS);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int IDX_LO   = 2 + OFFSET_BITS;
    localparam int TAG_LO   = IDX_LO + INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES][WORDS];

    fill_state_e            state;
    logic [OFFSET_BITS-1:0] ctr;
    logic [31:0]            fill_addr;
    logic                   word_we;
    logic                   last_done;

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_offset;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [OFFSET_BITS-1:0] fill_offset;
    logic abort, accept, tag_hit, hit, miss;
    logic unused_addr_bits;

    assign req_tag     = bus.read_addr[31:TAG_LO];
    assign req_index   = bus.read_addr[TAG_LO-1:IDX_LO];
    assign req_offset  = bus.read_addr[IDX_LO-1:2];
    assign fill_index  = fill_addr[TAG_LO-1:IDX_LO];
    assign fill_offset = fill_addr[IDX_LO-1:2];
    assign unused_addr_bits = ^{bus.read_addr[1:0], fill_addr[31:TAG_LO], fill_addr[1:0]};

    assign abort   = flush_pipline | invalidate_all;
    assign accept  = (state == IDLE) && bus.is_reading && rdy_in && !abort;
    assign tag_hit = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign hit     = accept && tag_hit;
    assign miss    = accept && !tag_hit;

    icache_refill_fsm #(.OFFSET_BITS(OFFSET_BITS)) u_refill (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .abort       (abort),
        .start       (miss),
        .start_addr  (bus.read_addr),
        .mem_done    (bus.mem_done),
        .state       (state),
        .ctr         (ctr),
        .fill_addr   (fill_addr),
        .mem_request (bus.mem_request),
        .mem_addr    (bus.mem_addr),
        .word_we     (word_we),
        .last_done   (last_done)
    );

    assign bus.icache_available = (state == IDLE);

    // Response: a hit answers from the array; the last refill word forwards
    // mem_data_in when it is the requested word, since it is not written yet.
    always_comb begin
        bus.is_ready  = 1'b0;
        bus.read_data = '0;
        if (hit) begin
            bus.is_ready  = 1'b1;
            bus.read_data = data_mem[req_index][req_offset];
        end else if (last_done) begin
            bus.is_ready  = 1'b1;
            bus.read_data = (fill_offset == '1) ? bus.mem_data_in
                                                : data_mem[fill_index][fill_offset];
        end
    end

    // Valid bits: invalidate_all clears everything and beats a same-cycle line completion.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (rdy_in) begin
            if (invalidate_all) begin
                valid <= '0;
            end else begin
                if (miss)      valid[req_index]  <= 1'b0;
                if (last_done) valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: tag written at the miss, data word by word during refill.
    always_ff @(posedge clk_in) begin
        // NOTE: storage arrays carry no reset; the valid bits alone say whether contents mean anything.
        if (rdy_in) begin
            if (miss)    tag_mem[req_index]       <= req_tag;
            if (word_we) data_mem[fill_index][ctr] <= bus.mem_data_in;
        end
    end

    // Saturating hit/miss counters.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            if (hit && hit_count != '1)   hit_count  <= hit_count + 1'b1;
            if (miss && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_line_instruction_cache.sv
// Directed bench for line_instruction_cache: scoreboard queues hold the
// expected adaptor addresses and expected read data.
module tb_line_instruction_cache;

    localparam int PW = 8;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          flush_pipline;
    logic          invalidate_all;
    logic [PW-1:0] hit_count;
    logic [PW-1:0] miss_count;

    line_instruction_cache_if bus ();

    line_instruction_cache #(.INDEX_BITS(6), .OFFSET_BITS(2), .PERF_WIDTH(PW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_pipline  (flush_pipline),
        .invalidate_all (invalidate_all),
        .bus            (bus),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int hits  = 0;
    int misses = 0;
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Compare the current read_data against the oldest expected word.
    task automatic pop_data(input string tag);
        logic [31:0] e;
        if (exp_data.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, bus.read_data);
        end else begin
            e = exp_data.pop_front();
            check(tag, bus.read_data, e);
        end
    endtask

    // One lookup, driven just after a rising edge and sampled mid-cycle.
    task automatic lookup(input logic [31:0] a, input bit exp_hit);
        bus.read_addr  = a;
        bus.is_reading = 1'b1;
        exp_data.push_back(mem_model(a));
        #2;
        check("available", 32'(bus.icache_available), 32'd1);
        check("lookup_is_ready", 32'(bus.is_ready), 32'(exp_hit));
        if (exp_hit) begin
            pop_data("hit_data");
            hits = (hits == 255) ? 255 : hits + 1;
        end else begin
            misses = (misses == 255) ? 255 : misses + 1;
            for (int w = 0; w < 4; w++) exp_addr.push_back({a[31:4], 4'(w * 4)});
        end
        tick();
        bus.is_reading = 1'b0;
        bus.read_addr  = '0;
        check("mem_request_after_lookup", 32'(bus.mem_request), 32'(!exp_hit));
        check("hit_count", 32'(hit_count), 32'(hits));
        check("miss_count", 32'(miss_count), 32'(misses));
    endtask

    // Serve one adaptor transaction; abort_kind 1 = flush, 2 = invalidate on the done cycle.
    task automatic serve(input int lat, input int abort_kind, input bit is_last);
        int n = 0;
        logic [31:0] a;
        while (!bus.mem_request && n < 50) begin
            tick();
            n++;
        end
        check("mem_request_wait", 32'(bus.mem_request), 32'd1);
        if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $error("FAIL mem_addr observed=0x%08h expected=<empty scoreboard>", bus.mem_addr);
            a = bus.mem_addr;
        end else begin
            a = exp_addr.pop_front();
            check("mem_addr", bus.mem_addr, a);
        end
        for (int i = 0; i < lat; i++) begin
            tick();
            check("is_ready_while_waiting", 32'(bus.is_ready), 32'd0);
        end
        bus.mem_done    = 1'b1;
        bus.mem_data_in = mem_model(a);
        flush_pipline   = (abort_kind == 1);
        invalidate_all  = (abort_kind == 2);
        #2;
        if (abort_kind != 0) begin
            check("is_ready_on_abort", 32'(bus.is_ready), 32'd0);
        end else begin
            check("is_ready_on_done", 32'(bus.is_ready), 32'(is_last));
            if (is_last) pop_data("fill_data");
        end
        tick();
        bus.mem_done    = 1'b0;
        bus.mem_data_in = '0;
        flush_pipline   = 1'b0;
        invalidate_all  = 1'b0;
    endtask

    task automatic fill(input int lat);
        for (int i = 0; i < 4; i++) serve(lat + (i % 2), 0, i == 3);
        check("available_after_fill", 32'(bus.icache_available), 32'd1);
        check("mem_request_after_fill", 32'(bus.mem_request), 32'd0);
    endtask

    initial begin
        rst_in          = 1'b1;
        rdy_in          = 1'b1;
        flush_pipline   = 1'b0;
        invalidate_all  = 1'b0;
        bus.read_addr   = '0;
        bus.is_reading  = 1'b0;
        bus.mem_data_in = '0;
        bus.mem_done    = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_is_ready", 32'(bus.is_ready), 32'd0);
        check("rst_available", 32'(bus.icache_available), 32'd1);
        check("rst_mem_request", 32'(bus.mem_request), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        rst_in = 1'b0;
        tick();

        // Cold miss, refill 0x1000..0x100C, then a same-line hit.
        lookup(32'h0000_1000, 1'b0);
        fill(1);
        lookup(32'h0000_1008, 1'b1);

        // Alias with last-word request forwards mem_data_in, then evicts 0x1000.
        lookup(32'h0000_200C, 1'b0);
        fill(0);
        lookup(32'h0000_1000, 1'b0);
        fill(2);

        // Flush after the second done (a done in the flush cycle is discarded).
        lookup(32'h0000_1440, 1'b0);
        serve(1, 0, 1'b0);
        serve(0, 0, 1'b0);
        serve(0, 1, 1'b0);
        check("flush_mem_request", 32'(bus.mem_request), 32'd0);
        check("flush_available", 32'(bus.icache_available), 32'd1);
        exp_addr.delete();
        exp_data.delete();
        lookup(32'h0000_1440, 1'b0);
        fill(1);

        // Three lines cached, invalidate_all in IDLE, all re-reads miss.
        lookup(32'h0000_1880, 1'b0);
        fill(0);
        lookup(32'h0000_1884, 1'b1);
        invalidate_all = 1'b1;
        tick();
        invalidate_all = 1'b0;
        lookup(32'h0000_1004, 1'b0);
        fill(0);
        lookup(32'h0000_1444, 1'b0);
        fill(0);
        lookup(32'h0000_1888, 1'b0);
        fill(0);

        // invalidate_all on the last-word done leaves the line invalid.
        lookup(32'h0000_1CC0, 1'b0);
        serve(0, 0, 1'b0);
        serve(0, 0, 1'b0);
        serve(0, 0, 1'b0);
        serve(0, 2, 1'b1);
        exp_addr.delete();
        exp_data.delete();
        lookup(32'h0000_1CC0, 1'b0);
        fill(1);

        // Spurious mem_done in IDLE is ignored.
        bus.mem_done    = 1'b1;
        bus.mem_data_in = 32'hDEAD_BEEF;
        #2;
        check("spurious_is_ready", 32'(bus.is_ready), 32'd0);
        tick();
        bus.mem_done    = 1'b0;
        bus.mem_data_in = '0;
        check("spurious_mem_request", 32'(bus.mem_request), 32'd0);
        lookup(32'h0000_1CC4, 1'b1);

        // rdy_in low in IDLE blocks a would-be hit.
        rdy_in         = 1'b0;
        bus.read_addr  = 32'h0000_1CC4;
        bus.is_reading = 1'b1;
        #2;
        check("rdy_low_idle_is_ready", 32'(bus.is_ready), 32'd0);
        tick();
        rdy_in         = 1'b1;
        bus.is_reading = 1'b0;
        check("rdy_low_idle_hit_count", 32'(hit_count), 32'(hits));

        // rdy_in low for 5 cycles mid-fill freezes the refill.
        lookup(32'h0000_2100, 1'b0);
        serve(1, 0, 1'b0);
        rdy_in         = 1'b0;
        bus.read_addr  = 32'h0000_2100;
        bus.is_reading = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("frozen_mem_addr", bus.mem_addr, 32'h0000_2104);
            check("frozen_mem_request", 32'(bus.mem_request), 32'd1);
            check("frozen_is_ready", 32'(bus.is_ready), 32'd0);
            tick();
        end
        rdy_in         = 1'b1;
        bus.is_reading = 1'b0;
        serve(0, 0, 1'b0);
        serve(2, 0, 1'b0);
        serve(1, 0, 1'b1);

        // Drive hit_count into saturation, then one more hit must hold it.
        while (hits < 255) lookup(32'h0000_2104, 1'b1);
        lookup(32'h0000_210C, 1'b1);
        check("hit_count_saturated", 32'(hit_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
